// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side bus of the shared single-port memory arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory environment.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              if_stall;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              dm_stall;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
   localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT} arbStateT;

   arbStateT          state,      stateNxt;
   logic [LAT_W-1:0]  latCnt,     latCntNxt;
   logic [STV_W-1:0]  starveCnt,  starveCntNxt;
   logic              ownerData,  ownerDataNxt;
   logic              ownerWe,    ownerWeNxt;
   logic              memEn,      memEnNxt;
   logic              memWe,      memWeNxt;
   logic [ADDR_W-1:0] memAddr,    memAddrNxt;
   logic [DATA_W-1:0] memWdata,   memWdataNxt;
   logic [DATA_W-1:0] ifRdata,    ifRdataNxt;
   logic [DATA_W-1:0] dmRdata,    dmRdataNxt;
   logic              ifValid,    ifValidNxt;
   logic              dmValid,    dmValidNxt;
   logic              grantOk;
   logic              fetchWins;

   // The completion cycle is spent in IDLE without granting so the finishing requester can update.
   assign grantOk   = !ifValid && !dmValid && (bus.if_req || bus.dm_req);
   assign fetchWins = bus.if_req && (!bus.dm_req || (starveCnt == STV_W'(STARVE_MAX)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         latCnt    <= '0;
         starveCnt <= '0;
         ownerData <= 1'b0;
         ownerWe   <= 1'b0;
         memEn     <= 1'b0;
         memWe     <= 1'b0;
         memAddr   <= '0;
         memWdata  <= '0;
         ifRdata   <= '0;
         dmRdata   <= '0;
         ifValid   <= 1'b0;
         dmValid   <= 1'b0;
      end else begin
         state     <= stateNxt;
         latCnt    <= latCntNxt;
         starveCnt <= starveCntNxt;
         ownerData <= ownerDataNxt;
         ownerWe   <= ownerWeNxt;
         memEn     <= memEnNxt;
         memWe     <= memWeNxt;
         memAddr   <= memAddrNxt;
         memWdata  <= memWdataNxt;
         ifRdata   <= ifRdataNxt;
         dmRdata   <= dmRdataNxt;
         ifValid   <= ifValidNxt;
         dmValid   <= dmValidNxt;
      end
   end

   always_comb begin
      stateNxt     = state;
      latCntNxt    = latCnt;
      starveCntNxt = starveCnt;
      ownerDataNxt = ownerData;
      ownerWeNxt   = ownerWe;
      memEnNxt     = 1'b0;
      memWeNxt     = 1'b0;
      memAddrNxt   = memAddr;
      memWdataNxt  = memWdata;
      ifRdataNxt   = ifRdata;
      dmRdataNxt   = dmRdata;
      ifValidNxt   = 1'b0;
      dmValidNxt   = 1'b0;

      case (state)
         IDLE: begin
            // mem_* are loaded on the grant edge so the strobe is visible throughout ACCESS.
            if (grantOk) begin
               stateNxt = ACCESS;
               memEnNxt = 1'b1;
               if (fetchWins) begin
                  ownerDataNxt = 1'b0;
                  ownerWeNxt   = 1'b0;
                  memAddrNxt   = bus.if_addr;
                  starveCntNxt = '0;
               end else begin
                  ownerDataNxt = 1'b1;
                  ownerWeNxt   = bus.dm_we;
                  memWeNxt     = bus.dm_we;
                  memAddrNxt   = bus.dm_addr;
                  memWdataNxt  = bus.dm_wdata;
                  if (bus.if_req && (starveCnt != STV_W'(STARVE_MAX))) begin
                     starveCntNxt = starveCnt + STV_W'(1);
                  end
               end
            end
         end
         ACCESS: begin
            latCntNxt = LAT_W'(MEM_LAT);
            stateNxt  = WAIT;
         end
         WAIT: begin
            latCntNxt = latCnt - LAT_W'(1);
            if (latCnt == LAT_W'(1)) begin
               stateNxt = IDLE;
               if (ownerData) begin
                  dmValidNxt = 1'b1;
                  if (!ownerWe) begin
                     dmRdataNxt = bus.mem_rdata;
                  end
               end else begin
                  ifValidNxt = 1'b1;
                  ifRdataNxt = bus.mem_rdata;
               end
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   assign bus.if_rdata  = ifRdata;
   assign bus.if_valid  = ifValid;
   assign bus.if_stall  = bus.if_req & ~ifValid;
   assign bus.dm_rdata  = dmRdata;
   assign bus.dm_valid  = dmValid;
   assign bus.dm_stall  = bus.dm_req & ~dmValid;
   assign bus.mem_en    = memEn;
   assign bus.mem_we    = memWe;
   assign bus.mem_addr  = memAddr;
   assign bus.mem_wdata = memWdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed timing cases, reset abandon, random traffic,
// plus a second instance with a three-cycle memory for the latency case.
module tb_mem_port_arbiter;
   localparam int unsigned MEM_LAT    = 1;
   localparam int unsigned STARVE_MAX = 4;
   localparam int unsigned LAT3       = 3;

   logic clk;
   logic rst;

   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus  ();
   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus3 ();

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX))
      dut (.clk(clk), .rst(rst), .bus(bus));

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT3), .STARVE_MAX(STARVE_MAX))
      dut3 (.clk(clk), .rst(rst), .bus(bus3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] ifQ[$];
   logic [15:0] dmQ[$];
   logic [15:0] refMem[logic [15:0]];
   logic [15:0] expDm;
   int nf, nd, nfr, ndr, n3, en3;

   // Memory contents before any store: a few preset words, otherwise an address hash.
   function automatic logic [15:0] memInit(input logic [15:0] a);
      case (a)
         16'h8004: return 16'hA123;
         16'h0010: return 16'h55AA;
         default:  return a ^ 16'hC35A;
      endcase
   endfunction

   function automatic logic [15:0] refRead(input logic [15:0] a);
      if (refMem.exists(a)) return refMem[a];
      return memInit(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Synchronous memory model: read data valid MEM_LAT cycles after the strobe, noise otherwise.
   bit          hwWr  [65536];
   logic [15:0] hwMem [65536];
   logic [15:0] pipeD [MEM_LAT];
   bit          pipeV [MEM_LAT];
   logic [15:0] noise;
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) begin
         hwWr[bus.mem_addr]  <= 1'b1;
         hwMem[bus.mem_addr] <= bus.mem_wdata;
      end
      pipeV[0] <= bus.mem_en && !bus.mem_we;
      pipeD[0] <= hwWr[bus.mem_addr] ? hwMem[bus.mem_addr] : memInit(bus.mem_addr);
      for (int i = 1; i < int'(MEM_LAT); i++) begin
         pipeV[i] <= pipeV[i-1];
         pipeD[i] <= pipeD[i-1];
      end
      noise <= 16'($urandom);
   end
   assign bus.mem_rdata = pipeV[MEM_LAT-1] ? pipeD[MEM_LAT-1] : noise;

   logic [15:0] pipe3D [LAT3];
   bit          pipe3V [LAT3];
   always @(posedge clk) begin
      pipe3V[0] <= bus3.mem_en && !bus3.mem_we;
      pipe3D[0] <= memInit(bus3.mem_addr);
      for (int i = 1; i < int'(LAT3); i++) begin
         pipe3V[i] <= pipe3V[i-1];
         pipe3D[i] <= pipe3D[i-1];
      end
   end
   assign bus3.mem_rdata = pipe3V[LAT3-1] ? pipe3D[LAT3-1] : noise;

   task automatic idle(input int k);
      repeat (k) begin @(posedge clk); #1; end
   endtask

   // Requests are issued #1 after a rising edge and held until the completion pulse.
   task automatic fetchReq(input logic [15:0] a, output int n);
      bus.if_req  = 1'b1;
      bus.if_addr = a;
      ifQ.push_back(refRead(a));
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus.if_valid && n < 300);
      if (!bus.if_valid) begin
         checks++; failures++;
         $display("FAIL fetch_timeout waited=%0d required=if_valid addr=%0h", n, a);
      end
   endtask

   task automatic dataReq(input logic we, input logic [15:0] a, input logic [15:0] d, output int n);
      bus.dm_req   = 1'b1;
      bus.dm_we    = we;
      bus.dm_addr  = a;
      bus.dm_wdata = d;
      if (we) refMem[a] = d;
      else    expDm = refRead(a);
      dmQ.push_back(expDm);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus.dm_valid && n < 300);
      if (!bus.dm_valid) begin
         checks++; failures++;
         $display("FAIL data_timeout waited=%0d required=dm_valid addr=%0h", n, a);
      end
   endtask

   // Monitor: stalls, grant order, strobe/latency timing and scoreboard pops on completions.
   initial begin
      int   streak, enCyc;
      logic prevIf, prevDm, prevEn, fetchOwn, expFetch;
      streak = 0; enCyc = -1; prevIf = 1'b0; prevDm = 1'b0; prevEn = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            streak = 0; enCyc = -1; prevIf = 1'b0; prevDm = 1'b0; prevEn = 1'b0;
            continue;
         end
         check("if_stall", 32'(bus.if_stall), 32'(bus.if_req & ~bus.if_valid));
         check("dm_stall", 32'(bus.dm_stall), 32'(bus.dm_req & ~bus.dm_valid));
         if (bus.if_valid && bus.dm_valid) check("both_valid", 32'(1), 32'(0));
         if (bus.mem_en) begin
            check("mem_en_single_cycle", 32'(prevEn), 32'(0));
            fetchOwn = bus.mem_addr[15];
            expFetch = prevIf && (!prevDm || streak == int'(STARVE_MAX));
            check("grant_owner_fetch", 32'(fetchOwn), 32'(expFetch));
            if (fetchOwn) begin
               streak = 0;
               check("fetch_mem_we", 32'(bus.mem_we), 32'(0));
               check("fetch_mem_addr", 32'(bus.mem_addr), 32'(bus.if_addr));
            end else begin
               if (prevIf && streak < int'(STARVE_MAX)) streak++;
               check("data_mem_we", 32'(bus.mem_we), 32'(bus.dm_we));
               check("data_mem_addr", 32'(bus.mem_addr), 32'(bus.dm_addr));
               if (bus.dm_we) check("data_mem_wdata", 32'(bus.mem_wdata), 32'(bus.dm_wdata));
            end
            enCyc = cyc;
         end
         if ((bus.if_valid || bus.dm_valid) && enCyc >= 0)
            check("strobe_to_valid", 32'(cyc - enCyc), 32'(MEM_LAT + 1));
         if (bus.if_valid) begin
            if (ifQ.size() == 0) check("if_valid_unexpected", 32'(1), 32'(0));
            else check("if_rdata", 32'(bus.if_rdata), 32'(ifQ.pop_front()));
         end
         if (bus.dm_valid) begin
            if (dmQ.size() == 0) check("dm_valid_unexpected", 32'(1), 32'(0));
            else check("dm_rdata", 32'(bus.dm_rdata), 32'(dmQ.pop_front()));
         end
         prevIf = bus.if_req;
         prevDm = bus.dm_req;
         prevEn = bus.mem_en;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog elapsed required=TB_RESULT");
      $fatal(1, "bench did not terminate");
   end

   initial begin
      rst = 1'b0; expDm = '0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      bus3.if_req = 1'b0; bus3.if_addr = '0;
      bus3.dm_req = 1'b0; bus3.dm_we = 1'b0; bus3.dm_addr = '0; bus3.dm_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs_zero", 32'(|{bus.if_rdata, bus.if_valid, bus.dm_rdata, bus.dm_valid,
            bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'(0));
      rst = 1'b1;
      idle(1);

      // Fetch alone from idle.
      fetchReq(16'h8004, nf);
      bus.if_req = 1'b0;
      check("fetch_alone_latency", 32'(nf), 32'(3));
      idle(1);

      // Simultaneous requests: data first, then fetch.
      fork
         begin dataReq(1'b0, 16'h0010, 16'h0000, nd); bus.dm_req = 1'b0; end
         begin fetchReq(16'h8006, nf); bus.if_req = 1'b0; end
      join
      check("both_data_latency", 32'(nd), 32'(3));
      check("both_fetch_latency", 32'(nf), 32'(7));
      idle(1);

      // Continuous data traffic: fetch is served after STARVE_MAX data grants.
      fork
         begin
            for (int i = 0; i < 6; i++)
               dataReq(1'(i % 2), 16'($urandom_range(0, 31)), 16'($urandom), nd);
            bus.dm_req = 1'b0;
         end
         begin fetchReq(16'h8100, nf); bus.if_req = 1'b0; end
      join
      check("starve_fetch_latency", 32'(nf), 32'(4 * STARVE_MAX + 3));
      idle(1);

      // Store: strobe values checked by the monitor, dm_rdata must keep the last load.
      dataReq(1'b1, 16'h0020, 16'hBEEF, nd);
      bus.dm_req = 1'b0;
      check("store_latency", 32'(nd), 32'(3));
      idle(1);

      // Reset during WAIT abandons the access; the held request restarts afterwards.
      bus.if_req  = 1'b1;
      bus.if_addr = 16'h8200;
      nf = 0;
      do begin @(posedge clk); #1; nf++; end while (!bus.mem_en && nf < 10);
      check("reset_case_strobe_seen", 32'(bus.mem_en), 32'(1));
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("async_reset_outputs_zero", 32'(|{bus.if_rdata, bus.if_valid, bus.dm_rdata, bus.dm_valid,
            bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'(0));
      repeat (2) begin
         @(posedge clk); #1;
         check("no_valid_in_reset", 32'(bus.if_valid | bus.dm_valid), 32'(0));
      end
      rst = 1'b1;
      expDm = '0;
      ifQ.push_back(refRead(16'h8200));
      nf = 0;
      do begin @(posedge clk); #1; nf++; end while (!bus.if_valid && nf < 50);
      bus.if_req = 1'b0;
      check("restart_after_reset_latency", 32'(nf), 32'(3));
      idle(1);

      // Random concurrent traffic on both ports.
      fork
         begin
            int g;
            for (int i = 0; i < 40; i++) begin
               g = int'($urandom_range(0, 3));
               bus.if_req = 1'b0;
               idle(g);
               fetchReq({1'b1, 15'($urandom)}, nfr);
            end
            bus.if_req = 1'b0;
         end
         begin
            int g;
            for (int i = 0; i < 40; i++) begin
               g = int'($urandom_range(0, 3));
               bus.dm_req = 1'b0;
               idle(g);
               dataReq(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom), ndr);
            end
            bus.dm_req = 1'b0;
         end
      join
      idle(5);
      check("if_queue_drained", 32'(ifQ.size()), 32'(0));
      check("dm_queue_drained", 32'(dmQ.size()), 32'(0));

      // Three-cycle memory: valid five cycles after the request, single strobe.
      bus3.if_addr = 16'h9000;
      bus3.if_req  = 1'b1;
      n3 = 0; en3 = 0;
      do begin
         @(posedge clk); #1; n3++;
         if (bus3.mem_en) en3++;
      end while (!bus3.if_valid && n3 < 50);
      bus3.if_req = 1'b0;
      check("lat3_valid_cycle", 32'(n3), 32'(5));
      check("lat3_mem_en_cycles", 32'(en3), 32'(1));
      check("lat3_if_rdata", 32'(bus3.if_rdata), 32'(memInit(16'h9000)));
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
